// File: rtl/count_serializer.sv
// Framed serial transmitter for counter result words.
// One hold slot in front of a start/data/stop shifter; MSB first.
module count_serializer #(
  parameter int WIDTH = 4,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_frame,
  output logic             done
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t           state_q, state_n;
  logic [WIDTH-1:0] hold_q;
  logic             hold_full_q, hold_full_n;
  logic [WIDTH-1:0] shift_q, shift_n;
  logic [BW-1:0]    bit_q, bit_n;
  logic [DW-1:0]    div_q, div_n;
  logic             accept;
  logic             div_end;
  logic             ser_out_n;
  logic             frame_n;
  logic             done_n;

  assign in_ready = !hold_full_q;
  assign accept   = in_valid && !hold_full_q;
  assign div_end  = (div_q == DIV_LAST);

  // Next-state, shifter, counters and hold-flag update.
  always_comb begin
    state_n     = state_q;
    shift_n     = shift_q;
    bit_n       = bit_q;
    div_n       = div_q;
    hold_full_n = hold_full_q;
    done_n      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          state_n     = START;
          shift_n     = hold_q;
          hold_full_n = 1'b0;
          div_n       = '0;
        end
      end
      START: begin
        if (div_end) begin
          state_n = DATA;
          bit_n   = '0;
          div_n   = '0;
        end else begin
          div_n = div_q + 1'b1;
        end
      end
      DATA: begin
        if (div_end) begin
          div_n = '0;
          if (bit_q == BIT_LAST) begin
            state_n = STOP;
          end else begin
            shift_n = shift_q << 1;
            bit_n   = bit_q + 1'b1;
          end
        end else begin
          div_n = div_q + 1'b1;
        end
      end
      STOP: begin
        if (div_end) begin
          done_n = 1'b1;
          div_n  = '0;
          if (hold_full_q) begin
            state_n     = START;
            shift_n     = hold_q;
            hold_full_n = 1'b0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          div_n = div_q + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        div_n   = '0;
      end
    endcase
    if (accept) begin
      hold_full_n = 1'b1;
    end
  end

  // Line level and frame flag follow the state being entered.
  always_comb begin
    ser_out_n = 1'b1;
    frame_n   = (state_n != IDLE);
    unique case (state_n)
      START:   ser_out_n = 1'b0;
      DATA:    ser_out_n = shift_n[WIDTH-1];
      default: ser_out_n = 1'b1;
    endcase
  end

  // Control state and counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      bit_q       <= '0;
      div_q       <= '0;
    end else begin
      state_q     <= state_n;
      hold_full_q <= hold_full_n;
      shift_q     <= shift_n;
      bit_q       <= bit_n;
      div_q       <= div_n;
    end
  end

  // Hold register captures only on an accepted handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q <= '0;
    end else if (accept) begin
      hold_q <= in_data;
    end
  end

  // Registered outputs; reset drives the line idle at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ser_out   <= 1'b1;
      ser_frame <= 1'b0;
      done      <= 1'b0;
    end else begin
      ser_out   <= ser_out_n;
      ser_frame <= frame_n;
      done      <= done_n;
    end
  end

endmodule

// File: tb/tb_count_serializer.sv
// Bench for count_serializer: two instances (DIV=1, DIV=3)
// share stimulus and are compared against a frame-level model.
module tb_count_serializer;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_data;
  logic       rdy0, so0, fr0, dn0;
  logic       rdy1, so1, fr1, dn1;

  int checks;
  int failures;

  int         divs [2];
  int         fl   [2];
  int         pos  [2];
  logic [3:0] wd   [2];
  logic [3:0] hold [2];
  bit         hf   [2];
  bit         dn   [2];
  bit         acc  [2];

  count_serializer #(.WIDTH(4), .DIV(1)) u_div1 (
    .clk(clk), .reset(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(rdy0),
    .ser_out(so0), .ser_frame(fr0), .done(dn0)
  );

  count_serializer #(.WIDTH(4), .DIV(3)) u_div3 (
    .clk(clk), .reset(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(rdy1),
    .ser_out(so1), .ser_frame(fr1), .done(dn1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      fl[k]   = 0;
      pos[k]  = 0;
      wd[k]   = '0;
      hold[k] = '0;
      hf[k]   = 1'b0;
      dn[k]   = 1'b0;
      acc[k]  = 1'b0;
    end
  endtask

  // One rising edge: finish/advance the frame, start the next
  // from hold, or accept a new word into an empty hold.
  task automatic model_step(input int k, input logic v,
                            input logic [3:0] d);
    bit hf_pre;
    hf_pre = hf[k];
    dn[k]  = 1'b0;
    acc[k] = 1'b0;
    if (fl[k] > 0) begin
      if (fl[k] == 1) dn[k] = 1'b1;
      fl[k]--;
      pos[k]++;
    end
    if (fl[k] == 0 && hf_pre) begin
      fl[k]  = 6 * divs[k];
      pos[k] = 0;
      wd[k]  = hold[k];
      hf[k]  = 1'b0;
    end
    if (v && !hf_pre) begin
      hold[k] = d;
      hf[k]   = 1'b1;
      acc[k]  = 1'b1;
    end
  endtask

  function automatic logic exp_line(input int k);
    int b;
    if (fl[k] == 0) return 1'b1;
    b = pos[k] / divs[k];
    if (b == 0) return 1'b0;
    if (b == 5) return 1'b1;
    return wd[k][4-b];
  endfunction

  task automatic check_all();
    chk("d1_ser_out", 32'(so0), 32'(exp_line(0)));
    chk("d1_frame", 32'(fr0), 32'(fl[0] > 0));
    chk("d1_done", 32'(dn0), 32'(dn[0]));
    chk("d1_ready", 32'(rdy0), 32'(!hf[0]));
    chk("d3_ser_out", 32'(so1), 32'(exp_line(1)));
    chk("d3_frame", 32'(fr1), 32'(fl[1] > 0));
    chk("d3_done", 32'(dn1), 32'(dn[1]));
    chk("d3_ready", 32'(rdy1), 32'(!hf[1]));
  endtask

  // Inputs change at the falling edge; checks also at the falling edge.
  task automatic cycle(input logic v, input logic [3:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) model_reset();
      else model_step(k, v, d);
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 4'h0);
  endtask

  // Hold in_valid with a word until the DIV=1 instance takes it.
  task automatic send(input logic [3:0] w);
    int n;
    n = 0;
    do begin
      cycle(1'b1, w);
      n++;
    end while (!acc[0] && n < 100);
    chk("send_timeout", 32'(acc[0]), 32'd1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    divs[0]  = 1;
    divs[1]  = 3;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 4'h0;
    model_reset();
    @(negedge clk);
    idle(3);
    rst_n = 1'b1;
    idle(2);

    send(4'b1011);
    idle(25);

    cycle(1'b1, 4'hA);
    send(4'h5);
    idle(45);

    send(4'h3);
    send(4'hC);
    send(4'hF);
    idle(70);

    send(4'h6);
    send(4'h1);
    idle(2);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    idle(2);
    rst_n = 1'b1;
    idle(40);

    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 4'($urandom));
    end
    idle(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
